// File: rtl/rrarbx_pkg.sv
// rrarbx_pkg: shared definitions for the rrarbx round-robin arbiter.
// Holds the two-state FSM encoding and a helper that derives the grant
// index width from the requester count, so a parent can size IDXWID.
package rrarbx_pkg;

  // Arbiter states, one bit wide: waiting for requests, or holding a grant.
  typedef enum logic {
    RRARB_IDLE  = 1'b0,
    RRARB_GRANT = 1'b1
  } rrarb_state_e;

  // Smallest index width w (at least 1) with 2^w >= nreq.
  function automatic int rrarb_idxwid(input int nreq);
    int w;
    w = 1;
    while ((1 << w) < nreq) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/rrarbx_if.sv
// rrarbx_if: request/grant bundle between the requester array (master)
// and the round-robin arbiter (slave).
interface rrarbx_if #(
  parameter int NREQ   = 48,
  parameter int IDXWID = 6
);

  logic [NREQ-1:0]   req;
  logic              done;
  logic              gnt_vld;
  logic [IDXWID-1:0] gnt_idx;
  logic              busy;

  modport master (
    output req,
    output done,
    input  gnt_vld,
    input  gnt_idx,
    input  busy
  );

  modport slave (
    input  req,
    input  done,
    output gnt_vld,
    output gnt_idx,
    output busy
  );

endinterface

// File: rtl/rrarbx_ffsx.sv
// ffsx: combinational rotate-masked find-first-set.
// Finds the first set bit of i_req at or above i_start, wrapping from
// NREQ-1 back to 0. The request vector is laid out twice side by side and
// the lower copy has every bit below i_start cleared; a plain LSB-first
// priority encode of that double-width vector then lands either on a bit
// at/above the start (lower copy) or on a wrapped bit (upper copy), which
// avoids building a variable rotator.
module ffsx #(
  parameter int NREQ   = 48,
  parameter int IDXWID = 6
) (
  input  logic [NREQ-1:0]   i_req,
  input  logic [IDXWID-1:0] i_start,
  output logic              o_found,
  output logic [IDXWID-1:0] o_idx
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_masked;

  assign w_dbl = {i_req, i_req};

  // Clear the lower-copy bits that sit below the search start.
  always_comb begin
    w_masked = w_dbl;
    for (int i = 0; i < NREQ; i++) begin
      if (i < int'(i_start)) begin
        w_masked[i] = 1'b0;
      end
    end
  end

  // LSB-first priority encode; upper-copy hits fold back by NREQ.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      if (w_masked[i]) begin
        o_found = 1'b1;
        if (i >= NREQ) begin
          o_idx = IDXWID'(i - NREQ);
        end else begin
          o_idx = IDXWID'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rrarbx.sv
// rrarbx: parameterized round-robin arbiter.
// Picks one of NREQ requesters, searching upward from one past the last
// winner, and holds the grant until the owner raises done. The winner is
// presented as a registered binary index plus valid; busy mirrors valid.
// IDXWID must satisfy 2^IDXWID >= NREQ so every index fits.
// Optional feature macro: RRARB_BACK2BACK_EN -- when defined, done with
// other requesters pending re-arbitrates immediately (owner excluded)
// instead of passing through an idle cycle.
module rrarbx
  import rrarbx_pkg::*;
#(
  parameter int NREQ   = 48,
  parameter int IDXWID = rrarb_idxwid(NREQ)
) (
  input logic     clk,
  input logic     rst,
  rrarbx_if.slave bus
);

  localparam logic [IDXWID-1:0] LastIdx = IDXWID'(NREQ - 1);

  rrarb_state_e      r_state;
  rrarb_state_e      w_nextState;
  logic [IDXWID-1:0] r_ptr;
  logic [IDXWID-1:0] w_nextPtr;
  logic              r_gntVld;
  logic              w_nextGntVld;
  logic [IDXWID-1:0] r_gntIdx;
  logic [IDXWID-1:0] w_nextGntIdx;

  logic [IDXWID-1:0] w_start;
  logic [NREQ-1:0]   w_searchReq;
  logic              w_found;
  logic [IDXWID-1:0] w_winIdx;

  // Search begins one past the pointer, wrapping at NREQ (not 2^IDXWID).
  assign w_start = (r_ptr == LastIdx) ? '0 : (r_ptr + IDXWID'(1));

`ifdef RRARB_BACK2BACK_EN
  logic [NREQ-1:0] w_ownerBit;

  // While granting, the owner's own request is hidden from re-arbitration.
  assign w_ownerBit  = NREQ'(1) << r_gntIdx;
  assign w_searchReq = (r_state == RRARB_GRANT) ? (bus.req & ~w_ownerBit) : bus.req;
`else
  assign w_searchReq = bus.req;
`endif

  ffsx #(
    .NREQ   (NREQ),
    .IDXWID (IDXWID)
  ) u_ffsx (
    .i_req   (w_searchReq),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_winIdx)
  );

  // Next-state, pointer and output decisions; hold everything by default.
  always_comb begin
    w_nextState  = r_state;
    w_nextPtr    = r_ptr;
    w_nextGntVld = r_gntVld;
    w_nextGntIdx = r_gntIdx;
    case (r_state)
      RRARB_IDLE: begin
        if (w_found) begin
          w_nextState  = RRARB_GRANT;
          w_nextGntVld = 1'b1;
          w_nextGntIdx = w_winIdx;
          w_nextPtr    = w_winIdx;
        end else begin
          w_nextGntVld = 1'b0;
        end
      end
      RRARB_GRANT: begin
        if (bus.done) begin
`ifdef RRARB_BACK2BACK_EN
          if (w_found) begin
            w_nextState  = RRARB_GRANT;
            w_nextGntVld = 1'b1;
            w_nextGntIdx = w_winIdx;
            w_nextPtr    = w_winIdx;
          end else begin
            w_nextState  = RRARB_IDLE;
            w_nextGntVld = 1'b0;
          end
`else
          w_nextState  = RRARB_IDLE;
          w_nextGntVld = 1'b0;
`endif
        end
      end
      default: begin
        w_nextState  = RRARB_IDLE;
        w_nextGntVld = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset parks the pointer on the
  // last requester so requester 0 wins the first search.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RRARB_IDLE;
      r_ptr    <= LastIdx;
      r_gntVld <= 1'b0;
      r_gntIdx <= '0;
    end else begin
      r_state  <= w_nextState;
      r_ptr    <= w_nextPtr;
      r_gntVld <= w_nextGntVld;
      r_gntIdx <= w_nextGntIdx;
    end
  end

  assign bus.gnt_vld = r_gntVld;
  assign bus.gnt_idx = r_gntIdx;
  assign bus.busy    = r_gntVld;

endmodule

// File: tb/tb_rrarbx.sv
// tb_rrarbx: self-checking bench for rrarbx.
// Runs a 48-requester and a 5-requester arbiter side by side against a
// behavioural round-robin model, plus directed literal checks.
// Honours RRARB_BACK2BACK_EN the same way the design does.
module tb_rrarbx;

  localparam int N0 = 48;
  localparam int W0 = 6;
  localparam int N1 = 5;
  localparam int W1 = 3;

  logic clk = 1'b0;
  logic rst;

  logic [47:0] reqV  [2];
  logic        doneV [2];
  int          nreq  [2] = '{N0, N1};

  int mVld [2];
  int mIdx [2];
  int mPtr [2];
  int modelW;

  int nChecks = 0;
  int nFail   = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  rrarbx_if #(.NREQ(N0), .IDXWID(W0)) bus0 ();
  rrarbx_if #(.NREQ(N1), .IDXWID(W1)) bus1 ();

  assign bus0.req  = reqV[0];
  assign bus0.done = doneV[0];
  assign bus1.req  = reqV[1][N1-1:0];
  assign bus1.done = doneV[1];

  rrarbx #(.NREQ(N0), .IDXWID(W0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rrarbx #(.NREQ(N1), .IDXWID(W1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  function automatic int dutVld(input int k);
    return (k == 0) ? int'(bus0.gnt_vld) : int'(bus1.gnt_vld);
  endfunction

  function automatic int dutIdx(input int k);
    return (k == 0) ? int'(bus0.gnt_idx) : int'(bus1.gnt_idx);
  endfunction

  function automatic int dutBusy(input int k);
    return (k == 0) ? int'(bus0.busy) : int'(bus1.busy);
  endfunction

  // Round robin by definition: walk upward from start, wrapping at n.
  function automatic int searchFrom(input logic [47:0] r, input int start, input int n);
    int j;
    for (int s = 0; s < n; s++) begin
      j = (start + s) % n;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int k, input logic [47:0] r, input logic d);
    reqV[k]  = r;
    doneV[k] = d;
    tick();
  endtask

  task automatic applyReset();
    rst      = 1'b1;
    reqV[0]  = '0;
    reqV[1]  = '0;
    doneV[0] = 1'b0;
    doneV[1] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Hold all requests high, pulse done after each grant, check the order.
  task automatic runSequence(input int k, input int count);
    bit [47:0] seen;
    int waitCnt;
    seen    = '0;
    reqV[k] = '1;
    for (int g = 0; g < count; g++) begin
      waitCnt = 0;
      while (dutVld(k) == 0 && waitCnt < 4) begin
        tick();
        waitCnt++;
      end
      checkOutput($sformatf("seq%0d_vld_g%0d", k, g), dutVld(k), 1);
      checkOutput($sformatf("seq%0d_idx_g%0d", k, g), dutIdx(k), g % nreq[k]);
      checkOutput($sformatf("seq%0d_range", k), int'(dutIdx(k) < nreq[k]), 1);
      if (g < nreq[k]) seen[dutIdx(k)] = 1'b1;
      doneV[k] = 1'b1;
      tick();
      doneV[k] = 1'b0;
    end
    checkOutput($sformatf("seq%0d_distinct", k), $countones(seen), nreq[k]);
    reqV[k] = '0;
  endtask

  // Reference model: advances on every rising edge from the applied inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mVld[k] = 0;
        mIdx[k] = 0;
        mPtr[k] = nreq[k] - 1;
      end else if (mVld[k] == 0) begin
        modelW = searchFrom(reqV[k], (mPtr[k] + 1) % nreq[k], nreq[k]);
        if (modelW >= 0) begin
          mVld[k] = 1;
          mIdx[k] = modelW;
          mPtr[k] = modelW;
        end
      end else if (doneV[k]) begin
`ifdef RRARB_BACK2BACK_EN
        modelW = searchFrom(reqV[k] & ~(48'd1 << mIdx[k]), (mIdx[k] + 1) % nreq[k], nreq[k]);
`else
        modelW = -1;
`endif
        if (modelW >= 0) begin
          mIdx[k] = modelW;
          mPtr[k] = modelW;
        end else begin
          mVld[k] = 0;
        end
      end
    end
  end

  // Compare both arbiters against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput($sformatf("model%0d_vld", k), dutVld(k), mVld[k]);
        checkOutput($sformatf("model%0d_idx", k), dutIdx(k), mIdx[k]);
        checkOutput($sformatf("model%0d_busy", k), dutBusy(k), mVld[k]);
        checkOutput($sformatf("model%0d_range", k), int'(dutIdx(k) < nreq[k]), 1);
      end
    end
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    logic [47:0] rnd;
    rst      = 1'b1;
    reqV[0]  = '0;
    reqV[1]  = '0;
    doneV[0] = 1'b0;
    doneV[1] = 1'b0;
    applyReset();
    checkEn = 1'b1;
    checkOutput("rst_vld", dutVld(0), 0);
    checkOutput("rst_idx", dutIdx(0), 0);
    checkOutput("rst_busy", dutBusy(0), 0);

    // Single requester 0, long hold, then release.
    applyStimulus(0, 48'h0000_0000_0001, 1'b0);
    checkOutput("a_vld", dutVld(0), 1);
    checkOutput("a_idx", dutIdx(0), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 48'h0000_0000_0001, 1'b0);
      checkOutput("a_hold_idx", dutIdx(0), 0);
    end
    applyStimulus(0, 48'h0000_0000_0001, 1'b1);
    checkOutput("a_release_vld", dutVld(0), 0);
    applyStimulus(0, '0, 1'b0);

    // done while idle is ignored.
    applyReset();
    applyStimulus(0, '0, 1'b1);
    checkOutput("idle_done_vld", dutVld(0), 0);
    doneV[0] = 1'b0;

    // Full rotation over 48 and over 5 requesters.
    applyReset();
    runSequence(0, 49);
    applyReset();
    runSequence(1, 6);

    // Wrap-around from pointer 47 and full-circle regrant.
    applyReset();
    applyStimulus(0, 48'h8000_0000_0000, 1'b0);
    checkOutput("c_idx47", dutIdx(0), 47);
    applyStimulus(0, '0, 1'b1);
    checkOutput("c_rel_vld", dutVld(0), 0);
    applyStimulus(0, 48'h8000_0000_0001, 1'b0);
    checkOutput("c_wrap_idx0", dutIdx(0), 0);
    applyStimulus(0, '0, 1'b1);
    applyStimulus(0, 48'h8000_0000_0000, 1'b0);
    checkOutput("c_next_idx47", dutIdx(0), 47);
    applyStimulus(0, '0, 1'b1);
    applyStimulus(0, 48'h8000_0000_0000, 1'b0);
    checkOutput("c_circle_vld", dutVld(0), 1);
    checkOutput("c_circle_idx47", dutIdx(0), 47);
    applyStimulus(0, '0, 1'b1);
    doneV[0] = 1'b0;

    // Owner drops its request mid-grant; reset while granting.
    applyReset();
    applyStimulus(0, 48'h0000_0000_0008, 1'b0);
    checkOutput("e_idx3", dutIdx(0), 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 48'h0000_0000_0080, 1'b0);
      checkOutput("e_hold_vld", dutVld(0), 1);
      checkOutput("e_hold_idx3", dutIdx(0), 3);
    end
    rst = 1'b1;
    applyStimulus(0, '1, 1'b1);
    checkOutput("e_rst_vld", dutVld(0), 0);
    rst = 1'b0;
    applyStimulus(0, '1, 1'b0);
    checkOutput("e_after_rst_idx", dutIdx(0), 0);
    checkOutput("e_after_rst_vld", dutVld(0), 1);

    // Release with another requester pending.
    applyReset();
    applyStimulus(0, 48'h0000_0000_0204, 1'b0);
    checkOutput("f_idx2", dutIdx(0), 2);
    applyStimulus(0, 48'h0000_0000_0204, 1'b1);
`ifdef RRARB_BACK2BACK_EN
    checkOutput("f_b2b_vld", dutVld(0), 1);
    checkOutput("f_b2b_idx9", dutIdx(0), 9);
    doneV[0] = 1'b0;
`else
    checkOutput("f_gap_vld", dutVld(0), 0);
    applyStimulus(0, 48'h0000_0000_0204, 1'b0);
    checkOutput("f_next_vld", dutVld(0), 1);
    checkOutput("f_next_idx9", dutIdx(0), 9);
`endif

    // Randomized soak on both arbiters, model compare runs throughout.
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rnd = 48'({$urandom(), $urandom()});
        case ($urandom_range(0, 3))
          0: reqV[k] = '0;
          1: reqV[k] = rnd;
          2: reqV[k] = rnd & 48'({$urandom(), $urandom()}) & 48'({$urandom(), $urandom()});
          default: reqV[k] = 48'd1 << $urandom_range(0, nreq[k] - 1);
        endcase
        doneV[k] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
